store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
Parametrised MIPS store stage for SB, SH and SW.
- Computes the effective address and aligns the store data onto byte lanes with byte enables.
- Flags misaligned accesses.
- Queues accepted stores in a DEPTH-entry write buffer, drained to data memory over a valid/ready handshake.
- Sits between the register-read/execute stage and the data-memory port.

Parameters:
ADDR_W, 32, effective/memory address width (>=3); EA truncated to ADDR_W.
DEPTH, 4, store buffer entries; power of two, >=2.
CNT_W, $clog2(DEPTH+1), width of buf_count (derived, do not override).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
instruction  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
instr_valid  in  1  instruction/operands valid this cycle.
Read_data1  in  32  rs value (base).
Read_data2  in  32  rt value (store data).
store_ready  out  1  buffer can accept a store this cycle.
ALU_result  out  ADDR_W  effective address of last accepted store (registered).
misaligned  out  1  one-cycle pulse: last accepted store was misaligned and dropped.
MemWrite  out  1  memory write request valid (buffer head present).
mem_addr  out  ADDR_W  word-aligned write address.
Write_data  out  32  lane-aligned write data.
byte_en  out  4  byte-lane enables, bit i = bits [8i+7:8i].
mem_ready  in  1  memory accepts the request this cycle.
buf_count  out  CNT_W  occupied entries.

Behaviour:
- Reset (reset=0, async): buffer cleared, pointers 0, ALU_result=0, misaligned=0, MemWrite=0, mem_addr=0, Write_data=0, byte_en=0, buf_count=0. Pending stores are discarded; no partial write completes.
- Store opcodes: SB=6'b101000, SH=6'b101001, SW=6'b101011. Any other opcode with instr_valid=1 is ignored: no state change, no flag.
- store_ready = (buf_count < DEPTH). Combinational from count only; a pop in the same cycle does not free space for a push when full.
- Accept: instr_valid & store_ready & store opcode.
- EA = Read_data1 + sign_extend(imm), modulo 2^ADDR_W (carry discarded).
- On accept, ALU_result <= EA next edge; it holds otherwise.
- Misaligned: SH with EA[0]=1, or SW with EA[1:0]!=0. The store is not enqueued and misaligned=1 for exactly the following cycle. SB is never misaligned.
- Lane formatting (little-endian):
  - SB: byte_en = 4'b0001<<EA[1:0]; data = {4{rt[7:0]}}.
  - SH: byte_en = EA[1]?4'b1100:4'b0011; data = {2{rt[15:0]}}.
  - SW: byte_en = 4'b1111; data = rt.
  - Entry address = {EA[ADDR_W-1:2],2'b00}.
- Buffer: FIFO, registered, no bypass. Store accepted at edge N is visible on MemWrite/mem_addr/Write_data/byte_en after edge N, i.e. 1-cycle minimum latency.
- Drain: MemWrite = (buf_count != 0). Head entry drives mem_addr/Write_data/byte_en.
  - Transfer when MemWrite & mem_ready; head pops at that edge.
  - While MemWrite=1 & mem_ready=0, all memory outputs are held stable.
  - When empty, data outputs hold their last value and byte_en=0.
- Simultaneous push and pop (not full): count unchanged; order preserved.
- Pointers wrap modulo DEPTH; stores drain strictly in acceptance order.

Decomposition:
- store_pkg: opcode constants OP_SB/OP_SH/OP_SW; size enum {SZ_B, SZ_H, SZ_W}; entry struct {addr[ADDR_W], data[32], be[4]}.
- Sub-module store_fifo (generic DEPTH x width synchronous FIFO, async active-low reset, push/pop/full/empty/count).
- Decode, EA, misalignment check and lane formatting stay combinational in store_unit.

Test Plan:
- SW, Read_data1=0x0, imm=0x0004, Read_data2=0x12345678, mem_ready=1 -> ALU_result=0x4. Next cycle MemWrite=1, mem_addr=0x4, byte_en=1111, Write_data=0x12345678. One cycle later MemWrite=0.
- SB, Read_data1=0x1C, imm=0x0021, Read_data2=0xABCDEF01 -> ALU_result=0x3D, mem_addr=0x3C, byte_en=0010, Write_data=0x01010101. SH at EA 0x3E, rt=0xBEEF -> byte_en=1100, Write_data=0xBEEFBEEF.
- Negative offset: SW, Read_data1=0x100, imm=0xFFFC -> ALU_result=0xFC, mem_addr=0xFC.
- Misaligned: SH at EA 0x3, then SW at EA 0x6 -> misaligned pulses once per store, MemWrite stays 0, buf_count=0. LW (100011) with instr_valid=1 -> no effect.
- Backpressure: mem_ready=0, issue 5 SWs, data 0x1..0x5 -> store_ready=0 after 4th, 5th dropped, buf_count=4. Raise mem_ready -> 0x1..0x4 written in 4 consecutive cycles, then MemWrite=0.
- Reset mid-drain: 2 entries queued, mem_ready=0, drive reset=0 mid-cycle -> MemWrite=0, buf_count=0 immediately (async). After release, outputs stay at reset values until the next store.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: shared opcodes, access sizes and lane helpers for the store stage
package store_pkg;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Returns {data[31:0], be[3:0]} with the store value replicated onto every lane it may occupy
    function automatic logic [35:0] lane_fmt(input size_t sz, input logic [1:0] lo, input logic [31:0] rt);
        return sz == SZ_B ? {{4{rt[7:0]}}, 4'b0001 << lo} :
               sz == SZ_H ? {{2{rt[15:0]}}, lo[1] ? 4'b1100 : 4'b0011} :
                            {rt, 4'b1111};
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        return (sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00);
    endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: DEPTH x W synchronous FIFO, async active-low reset
//   i_push/i_pop : requests, ignored when full/empty respectively
//   i_data/o_data: write data / head entry
//   o_full/o_empty/o_count: occupancy status
module store_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/store_unit.sv
// store_unit: MIPS SB/SH/SW store stage with lane formatting and a drained write buffer
//   instruction/instr_valid/Read_data1/Read_data2: decoded store request and operands
//   store_ready, ALU_result, misaligned: acceptance status, last EA, misalignment pulse
//   MemWrite/mem_addr/Write_data/byte_en/mem_ready: memory write handshake
//   buf_count: buffered stores
module store_unit
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    input  logic [31:0]       Read_data1,
    input  logic [31:0]       Read_data2,
    output logic              store_ready,
    output logic [ADDR_W-1:0] ALU_result,
    output logic              misaligned,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       Write_data,
    output logic [3:0]        byte_en,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  buf_count
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } entry_t;

    logic [5:0]        w_op;
    logic              w_is_st, w_mis, w_acc, w_pop, w_full, w_empty, w_unused;
    size_t             w_size;
    logic [ADDR_W-1:0] w_ea;
    logic [35:0]       w_fmt;
    entry_t            w_entry, w_head;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] r_alu, r_last_addr;
    logic [31:0]       r_last_data;
    logic              r_mis;

    assign w_unused = ^instruction[25:16];
    assign w_op     = instruction[31:26];
    assign w_is_st  = w_op == OP_SB || w_op == OP_SH || w_op == OP_SW;
    assign w_size   = w_op == OP_SB ? SZ_B : w_op == OP_SH ? SZ_H : SZ_W;
    assign w_ea     = ADDR_W'(Read_data1 + {{16{instruction[15]}}, instruction[15:0]});
    assign w_mis    = is_misaligned(w_size, w_ea[1:0]);
    assign w_acc    = instr_valid & store_ready & w_is_st;
    assign w_fmt    = lane_fmt(w_size, w_ea[1:0], Read_data2);
    assign w_entry  = '{addr: {w_ea[ADDR_W-1:2], 2'b00}, data: w_fmt[35:4], be: w_fmt[3:0]};
    assign w_pop    = MemWrite & mem_ready;

    store_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .i_push (w_acc & ~w_mis),
        .i_pop  (w_pop),
        .i_data (w_entry),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    // Full-check uses the registered count only: a same-cycle pop never frees space for a push
    assign store_ready = ~w_full;
    assign buf_count   = w_count;
    assign ALU_result  = r_alu;
    assign misaligned  = r_mis;
    assign MemWrite    = ~w_empty;
    // An empty buffer keeps showing the last drained address/data with all lanes disabled
    assign mem_addr    = w_empty ? r_last_addr : w_head.addr;
    assign Write_data  = w_empty ? r_last_data : w_head.data;
    assign byte_en     = w_empty ? 4'b0000 : w_head.be;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu       <= '0;
            r_mis       <= 1'b0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            r_mis <= w_acc & w_mis;
            if (w_acc) r_alu <= w_ea;
            if (w_pop) begin
                r_last_addr <= w_head.addr;
                r_last_data <= w_head.data;
            end
        end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: randomized and directed checks of store_unit against a queue-based model
module tb_store_unit;
    localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011, LW = 6'b100011;

    logic        clk = 0, reset = 0;
    logic [31:0] instruction = 0, Read_data1 = 0, Read_data2 = 0;
    logic        instr_valid = 0, mem_ready = 0;
    logic        store_ready, misaligned, MemWrite;
    logic [31:0] ALU_result, mem_addr, Write_data;
    logic [3:0]  byte_en;
    logic [2:0]  buf_count;

    store_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .Read_data1(Read_data1), .Read_data2(Read_data2), .store_ready(store_ready),
        .ALU_result(ALU_result), .misaligned(misaligned), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .Write_data(Write_data), .byte_en(byte_en),
        .mem_ready(mem_ready), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t        q[$];
    ent_t        m_last;
    logic [31:0] m_alu;
    logic        m_mis;
    int          checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_alu  = 0;
        m_mis  = 0;
        m_last = '{0, 0, 0};
    endtask

    // Applies one clock edge worth of the store-stage rules to the model
    task automatic model_edge();
        logic [5:0]  op;
        logic [31:0] ea, rt;
        logic        acc, bad;
        ent_t        e;
        op  = instruction[31:26];
        rt  = Read_data2;
        ea  = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};
        acc = instr_valid && (op == SB || op == SH || op == SW) && q.size() < 4;
        bad = (op == SH && ea % 2 != 0) || (op == SW && ea % 4 != 0);
        e.a = ea - ea % 4;
        e.b = op == SB ? 4'(1 << (ea % 4)) : op == SH ? 4'(3 << (ea & 2)) : 4'hF;
        e.d = op == SB ? rt[7:0] * 32'h0101_0101 : op == SH ? rt[15:0] * 32'h0001_0001 : rt;
        m_mis = acc && bad;
        if (acc) m_alu = ea;
        if (q.size() != 0 && mem_ready) m_last = q.pop_front();
        if (acc && !bad) q.push_back(e);
    endtask

    task automatic check_outputs();
        check("store_ready", store_ready, q.size() < 4);
        check("buf_count", buf_count, q.size());
        check("MemWrite", MemWrite, q.size() != 0);
        check("ALU_result", ALU_result, m_alu);
        check("misaligned", misaligned, m_mis);
        check("mem_addr", mem_addr, q.size() != 0 ? q[0].a : m_last.a);
        check("Write_data", Write_data, q.size() != 0 ? q[0].d : m_last.d);
        check("byte_en", byte_en, q.size() != 0 ? q[0].b : 4'h0);
    endtask

    task automatic step(input logic [5:0] op, input logic [15:0] imm, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic v, input logic r);
        instruction = {op, 5'd1, 5'd2, imm};
        Read_data1  = rd1;
        Read_data2  = rd2;
        instr_valid = v;
        mem_ready   = r;
        #1;
        check("store_ready_pre", store_ready, q.size() < 4);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        reset = 1;

        step(SW, 16'h0004, 32'h0, 32'h1234_5678, 1, 1);
        check("tp_sw_alu", ALU_result, 32'h4);
        check("tp_sw_data", Write_data, 32'h1234_5678);
        step(SW, 0, 0, 0, 0, 1);
        check("tp_sw_drained", MemWrite, 0);

        step(SB, 16'h0021, 32'h1C, 32'hABCD_EF01, 1, 0);
        check("tp_sb_alu", ALU_result, 32'h3D);
        check("tp_sb_addr", mem_addr, 32'h3C);
        check("tp_sb_be", byte_en, 4'b0010);
        step(SH, 16'h0002, 32'h3C, 32'h0000_BEEF, 1, 1);
        check("tp_sh_be", byte_en, 4'b1100);
        check("tp_sh_data", Write_data, 32'hBEEF_BEEF);
        step(SW, 0, 0, 0, 0, 1);

        step(SW, 16'hFFFC, 32'h100, 32'hCAFE_0001, 1, 1);
        check("tp_neg_alu", ALU_result, 32'hFC);
        check("tp_neg_addr", mem_addr, 32'hFC);
        step(SW, 0, 0, 0, 0, 1);

        step(SH, 16'h0003, 32'h0, 32'h1111, 1, 1);
        check("tp_mis_sh", misaligned, 1);
        step(SW, 16'h0006, 32'h0, 32'h2222, 1, 1);
        check("tp_mis_sw", misaligned, 1);
        check("tp_mis_memwrite", MemWrite, 0);
        step(LW, 16'h0010, 32'h40, 32'h3333, 1, 1);
        check("tp_lw_nomis", misaligned, 0);
        check("tp_lw_alu", ALU_result, 32'h6);

        for (int i = 1; i <= 5; i++) step(SW, 16'(i * 4), 32'h200, 32'(i), 1, 0);
        check("tp_bp_full", buf_count, 4);
        check("tp_bp_ready", store_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            check("tp_bp_order", Write_data, 32'(i));
            step(SW, 0, 0, 0, 0, 1);
        end
        check("tp_bp_empty", MemWrite, 0);

        step(SW, 16'h0010, 32'h0, 32'hAAAA_0001, 1, 0);
        step(SB, 16'h0011, 32'h0, 32'h0000_00BB, 1, 0);
        #2;
        reset = 0;
        #1;
        model_reset();
        check("tp_rst_memwrite", MemWrite, 0);
        check("tp_rst_count", buf_count, 0);
        check_outputs();
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) step(SW, 16'h0020, 32'h0, 32'h5, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 4))
                0: op = SB;
                1: op = SH;
                2: op = SW;
                3: op = LW;
                default: op = 6'($urandom);
            endcase
            step(op, 16'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
